// File: rtl/airlock_sequencer.sv
// Airlock lock-cycle controller: round-robin arrive/leave arbitration, pressure
// matching, door dwells and pressure conversion driven by one-second countdowns.

module airlock_sequencer_checker #(
  parameter int TICK_DIV  = 50000000,
  parameter int FILL_SEC  = 7,
  parameter int DRAIN_SEC = 8,
  parameter int WAIT_SEC  = 5
) (
  input logic clk,
  input logic reset,
  input logic outer_door,
  input logic inner_door,
  input logic filling,
  input logic draining,
  input logic waiting,
  input logic pressurized
);

  // Checks parameter legality and the door/pressure safety invariants every cycle once out of reset.
  always @(posedge clk) begin
    assert (TICK_DIV >= 1) else $error("airlock: TICK_DIV must be >= 1");
    assert (FILL_SEC >= 1 && FILL_SEC <= 15) else $error("airlock: FILL_SEC out of range");
    assert (DRAIN_SEC >= 1 && DRAIN_SEC <= 15) else $error("airlock: DRAIN_SEC out of range");
    assert (WAIT_SEC >= 1 && WAIT_SEC <= 15) else $error("airlock: WAIT_SEC out of range");
    if (reset) begin
      assert (!(outer_door && inner_door)) else $error("airlock: both doors open");
      assert (!outer_door || pressurized) else $error("airlock: outer door open while depressurized");
      assert (!inner_door || !pressurized) else $error("airlock: inner door open while pressurized");
      assert (!((filling || draining) && (outer_door || inner_door)))
        else $error("airlock: pumping with a door open");
      assert ($countones({filling, draining, waiting}) <= 1)
        else $error("airlock: more than one of filling/draining/waiting");
    end
  end

endmodule

module airlock_sequencer #(
  parameter int TICK_DIV  = 50000000,
  parameter int FILL_SEC  = 7,
  parameter int DRAIN_SEC = 8,
  parameter int WAIT_SEC  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_arrive,
  input  logic       req_leave,
  output logic       grant_arrive,
  output logic       grant_leave,
  output logic       outer_door,
  output logic       inner_door,
  output logic       filling,
  output logic       draining,
  output logic       waiting,
  output logic       pressurized,
  output logic [3:0] count_val,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PREP       = 3'd1,
    OPEN_ENTRY = 3'd2,
    SEAL       = 3'd3,
    CONVERT    = 3'd4,
    OPEN_EXIT  = 3'd5,
    DONE       = 3'd6
  } state_t;

  localparam logic SIDE_ARRIVE = 1'b1;
  localparam logic SIDE_LEAVE  = 1'b0;

  localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]  FILL_N    = 4'(FILL_SEC);
  localparam logic [3:0]  DRAIN_N   = 4'(DRAIN_SEC);
  localparam logic [3:0]  WAIT_N    = 4'(WAIT_SEC);

  // Output vector order: {grant_arrive, grant_leave, outer, inner, filling, draining, waiting, done}.
  // An arrive cycle needs the chamber pressurized at entry and vented at exit; leave is the mirror.
  function automatic logic [7:0] decode_outputs(input state_t st, input logic side);
    logic [7:0] o;
    o = 8'd0;
    case (st)
      PREP:       o = {side, ~side, 1'b0, 1'b0, side, ~side, 1'b0, 1'b0};
      OPEN_ENTRY: o = {side, ~side, side, ~side, 1'b0, 1'b0, 1'b1, 1'b0};
      SEAL:       o = {side, ~side, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      CONVERT:    o = {side, ~side, 1'b0, 1'b0, ~side, side, 1'b0, 1'b0};
      OPEN_EXIT:  o = {side, ~side, ~side, side, 1'b0, 1'b0, 1'b1, 1'b0};
      DONE:       o = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default:    o = 8'd0;
    endcase
    return o;
  endfunction

  state_t        state_r, state_s;
  logic          side_r, side_s;
  logic          last_r, last_s;
  logic          press_r, press_s;
  logic [3:0]    count_r, count_s;
  logic [PW-1:0] presc_r, presc_s;
  logic [7:0]    out_r, out_s;
  logic          tick_s, timed_s, phase_end_s, pick_s;

  // Next-state, countdown and arbitration logic.
  always_comb begin
    state_s     = state_r;
    side_s      = side_r;
    last_s      = last_r;
    press_s     = press_r;
    count_s     = count_r;
    presc_s     = presc_r;
    pick_s      = SIDE_ARRIVE;
    tick_s      = (presc_r == PRESC_MAX);
    timed_s     = state_r inside {PREP, OPEN_ENTRY, CONVERT, OPEN_EXIT};
    phase_end_s = tick_s && (count_r == 4'd1);

    if (timed_s) begin
      if (tick_s) begin
        presc_s = '0;
        count_s = count_r - 4'd1;
      end else begin
        presc_s = presc_r + PW'(1);
      end
    end else begin
      presc_s = '0;
      count_s = 4'd0;
    end

    case (state_r)
      IDLE: begin
        if (req_arrive || req_leave) begin
          // A tie goes to whichever side was not served last.
          pick_s = (req_arrive && req_leave) ? ~last_r : req_arrive;
          side_s = pick_s;
          if (press_r != pick_s) begin
            state_s = PREP;
            count_s = pick_s ? FILL_N : DRAIN_N;
          end else begin
            state_s = OPEN_ENTRY;
            count_s = WAIT_N;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PREP: begin
        if (phase_end_s) begin
          press_s = ~press_r;
          state_s = OPEN_ENTRY;
          count_s = WAIT_N;
        end else begin
          state_s = PREP;
        end
      end
      OPEN_ENTRY: begin
        if (phase_end_s) begin
          state_s = SEAL;
          count_s = 4'd0;
        end else begin
          state_s = OPEN_ENTRY;
        end
      end
      SEAL: begin
        // The chamber matches the entry side here, so conversion always moves it to the other side.
        state_s = CONVERT;
        count_s = side_r ? DRAIN_N : FILL_N;
      end
      CONVERT: begin
        if (phase_end_s) begin
          press_s = ~press_r;
          state_s = OPEN_EXIT;
          count_s = WAIT_N;
        end else begin
          state_s = CONVERT;
        end
      end
      OPEN_EXIT: begin
        if (phase_end_s) begin
          state_s = DONE;
          count_s = 4'd0;
        end else begin
          state_s = OPEN_EXIT;
        end
      end
      DONE: begin
        last_s  = side_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        count_s = 4'd0;
        presc_s = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copy tracks the current state.
  always_comb begin
    out_s = decode_outputs(state_s, side_s);
  end

  // State, timer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      side_r  <= SIDE_LEAVE;
      last_r  <= SIDE_LEAVE;
      press_r <= 1'b0;
      count_r <= 4'd0;
      presc_r <= '0;
      out_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      side_r  <= side_s;
      last_r  <= last_s;
      press_r <= press_s;
      count_r <= count_s;
      presc_r <= presc_s;
      out_r   <= out_s;
    end
  end

  assign {grant_arrive, grant_leave, outer_door, inner_door,
          filling, draining, waiting, done} = out_r;
  assign pressurized = press_r;
  assign count_val   = count_r;

  airlock_sequencer_checker #(
    .TICK_DIV (TICK_DIV),
    .FILL_SEC (FILL_SEC),
    .DRAIN_SEC(DRAIN_SEC),
    .WAIT_SEC (WAIT_SEC)
  ) u_checker (
    .clk        (clk),
    .reset      (reset),
    .outer_door (outer_door),
    .inner_door (inner_door),
    .filling    (filling),
    .draining   (draining),
    .waiting    (waiting),
    .pressurized(pressurized)
  );

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer with TICK_DIV=2: phase lengths, countdowns,
// arbitration, mid-cycle reset and a random safety-invariant sweep.

module tb_airlock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_arrive, req_leave;
  logic       grant_arrive, grant_leave, outer_door, inner_door;
  logic       filling, draining, waiting, pressurized, done;
  logic [3:0] count_val;

  int n_cmp = 0;
  int n_bad = 0;

  airlock_sequencer #(
    .TICK_DIV (2),
    .FILL_SEC (7),
    .DRAIN_SEC(8),
    .WAIT_SEC (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_arrive  (req_arrive),
    .req_leave   (req_leave),
    .grant_arrive(grant_arrive),
    .grant_leave (grant_leave),
    .outer_door  (outer_door),
    .inner_door  (inner_door),
    .filling     (filling),
    .draining    (draining),
    .waiting     (waiting),
    .pressurized (pressurized),
    .count_val   (count_val),
    .done        (done)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({grant_arrive, grant_leave, outer_door, inner_door, filling,
                draining, waiting, pressurized, done, count_val});
  endfunction

  function automatic logic pick_sig(input int sel);
    case (sel)
      0:       return filling;
      1:       return draining;
      2:       return outer_door;
      3:       return inner_door;
      default: return 1'b0;
    endcase
  endfunction

  // Measures how long the selected output stays high and checks length and countdown ends.
  task automatic check_phase(input string tag, input int sel, input int exp_len, input int exp_first);
    int len;
    int first;
    int last;
    len   = 0;
    first = int'(count_val);
    last  = 0;
    while (pick_sig(sel) && len < 200) begin
      last = int'(count_val);
      len++;
      step(1);
    end
    check_val({tag, "_len"}, 32'(len), 32'(exp_len));
    check_val({tag, "_first"}, 32'(first), 32'(exp_first));
    check_val({tag, "_last"}, 32'(last), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 400) begin
      step(1);
      n++;
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    reset      = 1'b0;
    req_arrive = 1'b0;
    req_leave  = 1'b0;
    step(2);
    check_val("reset_outs", all_outs(), 32'd0);

    // Arrive from depressurized chamber: fill, outer dwell, seal, drain, inner dwell.
    reset      = 1'b1;
    req_arrive = 1'b1;
    step(1);
    check_val("a_grant", 32'(grant_arrive), 32'd1);
    check_val("a_fill_on", 32'(filling), 32'd1);
    check_phase("a_fill", 0, 14, 7);
    check_val("a_press_entry", 32'(pressurized), 32'd1);
    check_val("a_wait_on", 32'(waiting), 32'd1);
    check_phase("a_outer", 2, 10, 5);
    check_val("a_seal_quiet", 32'({outer_door, inner_door, filling, draining, waiting}), 32'd0);
    check_val("a_seal_grant", 32'(grant_arrive), 32'd1);
    step(1);
    check_phase("a_drain", 1, 16, 8);
    check_val("a_press_exit", 32'(pressurized), 32'd0);
    check_phase("a_inner", 3, 10, 5);
    check_val("a_done", 32'({done, grant_arrive, grant_leave}), 32'b100);
    req_arrive = 1'b0;
    step(1);
    check_val("a_idle", 32'({done, pressurized, count_val}), 32'd0);

    // Leave from depressurized chamber: prep skipped, fill during conversion.
    req_leave = 1'b1;
    step(1);
    check_val("b_grant", 32'({grant_arrive, grant_leave}), 32'b01);
    check_val("b_inner_now", 32'(inner_door), 32'd1);
    req_leave = 1'b0;
    check_phase("b_inner", 3, 10, 5);
    step(1);
    check_phase("b_fill", 0, 14, 7);
    check_phase("b_outer", 2, 10, 5);
    check_val("b_done", 32'(done), 32'd1);
    step(1);
    check_val("b_press", 32'(pressurized), 32'd1);

    // Arrive from pressurized chamber, request dropped during conversion.
    req_arrive = 1'b1;
    step(1);
    check_val("c_skip_prep", 32'({outer_door, filling, count_val}), 32'({1'b1, 1'b0, 4'd5}));
    check_phase("c_outer", 2, 10, 5);
    step(1);
    check_val("c_drain_on", 32'(draining), 32'd1);
    req_arrive = 1'b0;
    check_phase("c_drain", 1, 16, 8);
    check_phase("c_inner", 3, 10, 5);
    check_val("c_done", 32'(done), 32'd1);
    step(4);
    check_val("c_no_grant", 32'({grant_arrive, grant_leave, pressurized}), 32'd0);

    // Continuous tie: last served was ARRIVE, so LEAVE, ARRIVE, LEAVE, ARRIVE.
    req_arrive = 1'b1;
    req_leave  = 1'b1;
    step(1);
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("d_grant%0d", k), 32'({grant_arrive, grant_leave}),
                (k % 2 == 0) ? 32'b01 : 32'b10);
      wait_done($sformatf("d_done%0d", k));
      step(1);
      check_val($sformatf("d_idle%0d", k), 32'({grant_arrive, grant_leave, done}), 32'd0);
      step(1);
    end
    check_val("d_grant3", 32'({grant_arrive, grant_leave}), 32'b10);
    req_arrive = 1'b0;
    req_leave  = 1'b0;
    check_val("d_outer_now", 32'(outer_door), 32'd1);

    // Reset in the middle of OPEN_ENTRY, then the tie must go to ARRIVE.
    step(3);
    check_val("e_in_entry", 32'({outer_door, waiting}), 32'b11);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check_val("e_reset_outs", all_outs(), 32'd0);
    req_arrive = 1'b1;
    req_leave  = 1'b1;
    step(1);
    check_val("e_tie_arrive", 32'({grant_arrive, grant_leave, filling}), 32'b101);
    req_arrive = 1'b0;
    req_leave  = 1'b0;
    wait_done("e_done");
    step(1);

    // Random requests and occasional resets; safety invariants checked each cycle.
    for (int i = 0; i < 3000; i++) begin
      req_arrive = 1'($urandom_range(0, 1));
      req_leave  = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 299) != 0);
      step(1);
      ok = !(outer_door && inner_door) && (!outer_door || pressurized) &&
           (!inner_door || !pressurized) &&
           !((filling || draining) && (outer_door || inner_door)) &&
           (32'($countones({filling, draining, waiting})) <= 32'd1);
      if (!ok || i % 500 == 0) begin
        check_val($sformatf("r_safety%0d", i), 32'(ok), 32'd1);
      end
    end
    reset      = 1'b1;
    req_arrive = 1'b0;
    req_leave  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
